// File: rtl/pipe_xor_reduce.sv
// rtl/pipe_xor_reduce.sv - pipelined 6-ary XOR-reduction tree computing the parity of a wide vector
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset, clears every stage register
//   a      in  WIDTH  data vector, sampled every rising edge
//   out    out 1      registered parity of the vector sampled LATENCY edges earlier
module pipe_xor_reduce #(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic             out
);

    // Width of the register vector after k reduction stages.
    function automatic int stage_width(input int w, input int k);
        int r;
        r = w;
        for (int i = 0; i < k; i++) begin
            r = (r + 5) / 6;
        end
        return r;
    endfunction

    // Number of stages needed to reach a single bit; at least one so that
    // out always comes straight from a flop, even for WIDTH == 1.
    function automatic int calc_latency(input int w);
        int r;
        int n;
        r = w;
        n = 0;
        while (r > 1) begin
            r = (r + 5) / 6;
            n++;
        end
        return (n < 1) ? 1 : n;
    endfunction

    localparam int LATENCY = calc_latency(WIDTH);

    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
        localparam int IW = stage_width(WIDTH, k - 1);
        localparam int OW = stage_width(WIDTH, k);

        logic [IW-1:0]   stage_in;
        logic [OW*6-1:0] stage_pad;
        logic [OW-1:0]   stage_d;
        logic [OW-1:0]   stage_q;

        if (k == 1) begin : g_first
            assign stage_in = a;
        end else begin : g_next
            assign stage_in = g_stage[k-1].stage_q;
        end

        // Zero-extend to a whole number of 6-bit groups so the last, partial
        // group XORs only its real bits.
        always_comb begin
            stage_pad = '0;
            stage_pad[IW-1:0] = stage_in;
            stage_d = '0;
            for (int j = 0; j < OW; j++) begin
                stage_d[j] = ^stage_pad[j*6 +: 6];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign out = g_stage[LATENCY].stage_q[0];

endmodule

// File: tb/tb_pipe_xor_reduce.sv
// tb/tb_pipe_xor_reduce.sv - scoreboard testbench for pipe_xor_reduce across several widths
module tb_pipe_xor_reduce;

    localparam int NDUT = 8;
    localparam int MAXW = 217;
    localparam int W_TAB [NDUT] = '{100, 6, 7, 36, 37, 216, 217, 1};
    localparam int L_TAB [NDUT] = '{3, 1, 2, 2, 3, 3, 4, 1};

    logic            clk;
    logic            rst_n;
    logic [MAXW-1:0] a_all;
    logic [NDUT-1:0] out_v;

    int n_checks;
    int n_fail;

    bit exp_q [NDUT][$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipe_xor_reduce #(.WIDTH(W_TAB[g])) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .a    (a_all[W_TAB[g]-1:0]),
            .out  (out_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parity as "odd number of ones among the low w bits".
    function automatic bit ref_par(input logic [MAXW-1:0] v, input int w);
        int c;
        c = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) c++;
        end
        return bit'(c % 2);
    endfunction

    function automatic logic [MAXW-1:0] rand_vec();
        logic [MAXW-1:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom()};
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s width=%0d t=%0t got=%b expected=%b", name, W_TAB[idx], $time, act, exp);
        end
    endtask

    // Drive one vector before an edge; the expected parities enter the
    // scoreboard once the edge has sampled them.
    task automatic step(input logic [MAXW-1:0] v, input logic r);
        @(negedge clk);
        a_all = v;
        rst_n = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NDUT; i++) begin
                exp_q[i].push_back(ref_par(v, W_TAB[i]));
            end
        end
    endtask

    task automatic one_hot(input int bitpos);
        logic [MAXW-1:0] v;
        v = '0;
        v[bitpos] = 1'b1;
        step(v, 1'b1);
        for (int i = 0; i < 5; i++) step('0, 1'b1);
    endtask

    // Monitor: the oldest expectation is due once LATENCY samples are queued.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                check("reset_low", i, out_v[i], 1'b0);
            end else if (exp_q[i].size() == L_TAB[i]) begin
                check("parity", i, out_v[i], exp_q[i].pop_front());
            end
        end
    end

    initial begin
        logic [MAXW-1:0] v;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a_all    = '1;

        // Held in reset with all ones applied.
        for (int i = 0; i < 4; i++) step('1, 1'b0);
        // Release, keep all ones (even count for width 100).
        for (int i = 0; i < 10; i++) step('1, 1'b1);

        // Single-bit pulses at group and latency boundaries.
        one_hot(0);
        one_hot(5);
        one_hot(6);
        one_hot(35);
        one_hot(36);
        one_hot(99);
        one_hot(215);
        one_hot(216);

        // Width-1 toggle pattern.
        for (int i = 0; i < 12; i++) begin
            v = '0;
            v[0] = i[0];
            step(v, 1'b1);
        end

        // Back-to-back random stream.
        for (int i = 0; i < 1000; i++) step(rand_vec(), 1'b1);

        // Asynchronous reset asserted between edges mid-stream.
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) exp_q[i].delete();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) check("async_reset", i, out_v[i], 1'b0);
        for (int i = 0; i < 3; i++) step(rand_vec(), 1'b0);
        for (int i = 0; i < 200; i++) step(rand_vec(), 1'b1);

        for (int i = 0; i < 6; i++) step('0, 1'b1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
